soda_vend_ctrl: RTL

Sequencing controller for the soda machine. It accumulates coin credit, vends on a select request once credit reaches the price, and pays back change or cancelled credit one nickel per cycle. The 4-bit credit output, in nickel units 0..9, drives the credit-to-display converter directly. Credit never exceeds 9, so the converter's overflow code is never produced.

---
 rtl/soda_vend_ctrl_if.sv | 25 ++
 rtl/soda_vend_ctrl.sv | 126 ++++++++++++
 2 files changed

// File: rtl/soda_vend_ctrl_if.sv
// Coin, request and status signals shared between the soda machine
// front panel (master) and the vending sequencer (slave).
interface soda_vend_ctrl_if;
  logic       coin_n;
  logic       coin_d;
  logic       coin_q;
  logic       select;
  logic       cancel;
  logic [3:0] credit;
  logic       dispense;
  logic       change_nickel;
  logic       coin_reject;
  logic       busy;
  logic [1:0] state;

  modport master (
    output coin_n, coin_d, coin_q, select, cancel,
    input  credit, dispense, change_nickel, coin_reject, busy, state
  );

  modport slave (
    input  coin_n, coin_d, coin_q, select, cancel,
    output credit, dispense, change_nickel, coin_reject, busy, state
  );
endinterface

// File: rtl/soda_vend_ctrl.sv
// Soda machine sequencer: collects coin credit in nickel units, vends once
// credit reaches the price, then pays back the remainder (or the whole
// credit on cancel) one nickel per cycle. Credit is capped at MAX_CREDIT
// so it always fits the single-digit display converter.
module soda_vend_ctrl #(
  parameter int PRICE      = 5,
  parameter int MAX_CREDIT = 9,
  parameter int VAL_N      = 1,
  parameter int VAL_D      = 2,
  parameter int VAL_Q      = 5
) (
  input  logic           clk,
  input  logic           rst,
  soda_vend_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    COLLECT = 2'b01,
    VEND    = 2'b10,
    CHANGE  = 2'b11
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] credit_q, credit_d;
  logic       dispense_q, dispense_d;
  logic       change_nickel_q, change_nickel_d;
  logic       coin_reject_q, coin_reject_d;
  logic       busy_q, busy_d;

  logic [1:0] coin_cnt;
  logic       coin_any;
  logic [3:0] coin_val;
  logic [4:0] coin_sum;
  logic       coin_fits;
  logic       coin_accept;

  // Decode the coin inputs: a lone coin whose value still keeps credit within
  // MAX_CREDIT is a candidate for acceptance; the 5-bit sum cannot wrap.
  always_comb begin
    coin_cnt = {1'b0, bus.coin_n} + {1'b0, bus.coin_d} + {1'b0, bus.coin_q};
    coin_any = bus.coin_n | bus.coin_d | bus.coin_q;
    coin_val = 4'd0;
    if (bus.coin_n) begin
      coin_val = 4'(VAL_N);
    end else if (bus.coin_d) begin
      coin_val = 4'(VAL_D);
    end else if (bus.coin_q) begin
      coin_val = 4'(VAL_Q);
    end
    coin_sum  = {1'b0, credit_q} + {1'b0, coin_val};
    coin_fits = (coin_cnt == 2'd1) && (coin_sum <= 5'(MAX_CREDIT));
  end

  // Next-state and next-output logic; coins are only taken when the machine
  // stays in IDLE/COLLECT territory, every other coin is bounced.
  always_comb begin
    state_d     = state_q;
    credit_d    = credit_q;
    coin_accept = 1'b0;
    case (state_q)
      IDLE: begin
        if (coin_fits) begin
          coin_accept = 1'b1;
          credit_d    = coin_val;
          state_d     = COLLECT;
        end
      end
      COLLECT: begin
        if (bus.cancel) begin
          state_d = CHANGE;
        end else if (bus.select && (credit_q >= 4'(PRICE))) begin
          state_d = VEND;
        end else if (coin_fits) begin
          coin_accept = 1'b1;
          credit_d    = coin_sum[3:0];
        end
      end
      VEND: begin
        credit_d = credit_q - 4'(PRICE);
        state_d  = (credit_q > 4'(PRICE)) ? CHANGE : IDLE;
      end
      CHANGE: begin
        credit_d = credit_q - 4'd1;
        if (credit_q <= 4'd1) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d  = IDLE;
        credit_d = 4'd0;
      end
    endcase
    coin_reject_d   = coin_any && !coin_accept;
    dispense_d      = (state_d == VEND);
    change_nickel_d = (state_d == CHANGE);
    busy_d          = state_d[1];
  end

  // State, credit and all status outputs are held in flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      credit_q        <= 4'd0;
      dispense_q      <= 1'b0;
      change_nickel_q <= 1'b0;
      coin_reject_q   <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      credit_q        <= credit_d;
      dispense_q      <= dispense_d;
      change_nickel_q <= change_nickel_d;
      coin_reject_q   <= coin_reject_d;
      busy_q          <= busy_d;
    end
  end

  assign bus.credit        = credit_q;
  assign bus.dispense      = dispense_q;
  assign bus.change_nickel = change_nickel_q;
  assign bus.coin_reject   = coin_reject_q;
  assign bus.busy          = busy_q;
  assign bus.state         = state_q;

endmodule
